// File: rtl/mem_access_controller_pkg.sv
// Shared types for the data-memory access controller: size codes, FSM encoding
// and the alignment rule used when MEM_ALIGN_CHECK_EN is defined.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Size 2'b11 is treated as a word, so it shares the word alignment rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == SIZE_HALF) bad = addr_lo[0];
    else if (size[1]) bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Request/response and memory-pin bundle of the data-memory access controller.
// master = the controller; slave = the pipeline MEM stage plus the data memory.
interface mem_access_controller_if #(parameter int ADDR_W = 9);
  // Request handshake: a request transfers on a rising edge where ReqValid and
  // ReqReady are both 1; the requester holds ReqValid and its fields until then.
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [1:0]        ReqSize;
  logic              ReqSE;
  logic [ADDR_W-1:0] ReqAddr;
  logic [31:0]       ReqWData;
  logic              RespValid;
  logic [31:0]       RespData;
  logic              RespErr;
  logic              MemEnable;
  logic              MemReadWrite;
  logic              MemSE;
  logic [1:0]        MemSize;
  logic [ADDR_W-1:0] MemAddress;
  logic [31:0]       MemDataIn;
  logic [31:0]       MemDataOut;

  modport master (
    input  ReqValid, ReqWrite, ReqSize, ReqSE, ReqAddr, ReqWData, MemDataOut,
    output ReqReady, RespValid, RespData, RespErr,
    output MemEnable, MemReadWrite, MemSE, MemSize, MemAddress, MemDataIn
  );

  modport slave (
    output ReqValid, ReqWrite, ReqSize, ReqSE, ReqAddr, ReqWData, MemDataOut,
    input  ReqReady, RespValid, RespData, RespErr,
    input  MemEnable, MemReadWrite, MemSE, MemSize, MemAddress, MemDataIn
  );
endinterface

// File: rtl/mem_access_controller.sv
// Data-memory initiator: registered IDLE/ACCESS/RESP FSM holding the memory pins
// for WAIT_CYCLES+1 cycles. Optional alignment rejection under MEM_ALIGN_CHECK_EN.
module mem_access_controller
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  mem_access_controller_if.master bus,
  output state_e                 dbg_state_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_se_q, mem_se_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              reject;

`ifdef MEM_ALIGN_CHECK_EN
  assign reject = misaligned(bus.ReqSize, bus.ReqAddr[1:0]);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    mem_en_d     = mem_en_q;
    mem_rw_d     = mem_rw_q;
    mem_se_d     = mem_se_q;
    mem_size_d   = mem_size_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.ReqValid && ready_q) begin
          ready_d = 1'b0;
          if (reject) begin
            // Rejected requests leave the memory pins untouched.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
            state_d      = ST_RESP;
          end else begin
            mem_en_d    = 1'b1;
            mem_rw_d    = bus.ReqWrite;
            mem_se_d    = bus.ReqSE;
            mem_size_d  = (bus.ReqSize == 2'b11) ? SIZE_WORD : bus.ReqSize;
            mem_addr_d  = bus.ReqAddr;
            mem_wdata_d = bus.ReqWData;
            cnt_d       = CNT_W'(WAIT_CYCLES);
            state_d     = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          resp_data_d  = mem_rw_q ? 32'h0 : bus.MemDataOut;
          mem_en_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        ready_d      = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_se_q     <= 1'b0;
      mem_size_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      mem_se_q     <= mem_se_d;
      mem_size_q   <= mem_size_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.ReqReady     = ready_q;
  assign bus.RespValid    = resp_valid_q;
  assign bus.RespErr      = resp_err_q;
  assign bus.RespData     = resp_data_q;
  assign bus.MemEnable    = mem_en_q;
  assign bus.MemReadWrite = mem_rw_q;
  assign bus.MemSE        = mem_se_q;
  assign bus.MemSize      = mem_size_q;
  assign bus.MemAddress   = mem_addr_q;
  assign bus.MemDataIn    = mem_wdata_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: big-endian byte memory model, shadow reference
// memory, directed plan cases and randomized load/store traffic.
module tb_mem_access_controller;
  import mem_access_pkg::*;

  parameter int WAIT = 1;
  localparam int ADDR_W = 9;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic   Clk;
  logic   Reset_n;
  state_e dbg_state;
  int     n_vec  = 0;
  int     n_fail = 0;
  logic [31:0] exp_q[$];
  int     acc_q[$];
  int     cyc = 0;
  int     stab_err = 0;
  int     resp_cnt = 0;

  logic [7:0] mem    [512] = '{default: 8'h00};
  logic [7:0] shadow [512] = '{default: 8'h00};

  mem_access_controller_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- memory model (big-endian) ----------------
  function automatic logic [31:0] mem_read(input logic [7:0] arr [512], input logic [8:0] a,
                                           input logic [1:0] sz, input logic se);
    logic [31:0] v;
    logic [8:0]  a1, a2, a3;
    a1 = a + 9'd1; a2 = a + 9'd2; a3 = a + 9'd3;
    if (sz == 2'b00)      v = {{24{se & arr[a][7]}}, arr[a]};
    else if (sz == 2'b01) v = {{16{se & arr[a][7]}}, arr[a], arr[a1]};
    else                  v = {arr[a], arr[a1], arr[a2], arr[a3]};
    return v;
  endfunction

  assign bus.MemDataOut = mem_read(mem, bus.MemAddress, bus.MemSize, bus.MemSE);

  always @(posedge Clk) begin
    if (bus.MemEnable && bus.MemReadWrite) begin
      if (bus.MemSize == 2'b00) begin
        mem[bus.MemAddress] <= bus.MemDataIn[7:0];
      end else if (bus.MemSize == 2'b01) begin
        mem[bus.MemAddress]         <= bus.MemDataIn[15:8];
        mem[bus.MemAddress + 9'd1]  <= bus.MemDataIn[7:0];
      end else begin
        mem[bus.MemAddress]         <= bus.MemDataIn[31:24];
        mem[bus.MemAddress + 9'd1]  <= bus.MemDataIn[23:16];
        mem[bus.MemAddress + 9'd2]  <= bus.MemDataIn[15:8];
        mem[bus.MemAddress + 9'd3]  <= bus.MemDataIn[7:0];
      end
    end
  end

  // ---------------- monitors ----------------
  logic        prev_en = 1'b0;
  logic [44:0] prev_fields = '0;
  wire  [44:0] cur_fields = {bus.MemReadWrite, bus.MemSE, bus.MemSize, bus.MemAddress, bus.MemDataIn};

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Reset_n && bus.ReqValid && bus.ReqReady) acc_q.push_back(cyc);
  end

  always @(negedge Clk) begin
    if (bus.MemEnable && prev_en && cur_fields !== prev_fields) stab_err <= stab_err + 1;
    if (bus.RespValid) resp_cnt <= resp_cnt + 1;
    prev_en     <= bus.MemEnable;
    prev_fields <= cur_fields;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic ref_store(input logic [8:0] a, input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) begin
      shadow[a] = d[7:0];
    end else if (sz == 2'b01) begin
      shadow[a] = d[15:8]; shadow[a + 9'd1] = d[7:0];
    end else begin
      shadow[a] = d[31:24]; shadow[a + 9'd1] = d[23:16];
      shadow[a + 9'd2] = d[15:8]; shadow[a + 9'd3] = d[7:0];
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_fields(input logic w, input logic [1:0] sz, input logic se,
                              input logic [8:0] addr, input logic [31:0] wd);
    bus.ReqWrite = w; bus.ReqSize = sz; bus.ReqSE = se; bus.ReqAddr = addr; bus.ReqWData = wd;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.ReqReady && k < 50) begin
      @(negedge Clk);
      k++;
    end
    check_eq("req_ready_seen", 32'(bus.ReqReady), 32'd1);
  endtask

  // One full transaction: issue, observe the access window, check the response.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic se,
                         input logic [8:0] addr, input logic [31:0] wd);
    logic        mis, fields_ok, got_err;
    logic [1:0]  exp_sz;
    logic [8:0]  prev_addr;
    logic [31:0] got_data, exp_data;
    int          en_cnt, resp_at;
    mis    = ALIGN_EN && misaligned(sz, addr[1:0]);
    exp_sz = (sz == 2'b11) ? 2'b10 : sz;
    if (mis || w) exp_q.push_back(32'h0);
    else          exp_q.push_back(mem_read(shadow, addr, exp_sz, se));
    if (w && !mis) ref_store(addr, exp_sz, wd);
    @(negedge Clk);
    prev_addr = bus.MemAddress;
    bus.ReqValid = 1'b1;
    drive_fields(w, sz, se, addr, wd);
    wait_ready();
    @(negedge Clk);
    bus.ReqValid = 1'b0;
    en_cnt = 0; resp_at = 0; fields_ok = 1'b1;
    got_data = 32'hxxxxxxxx; got_err = 1'bx;
    for (int i = 1; i <= WAIT + 4 && resp_at == 0; i++) begin
      if (i > 1) @(negedge Clk);
      if (bus.MemEnable) begin
        en_cnt++;
        if (bus.MemReadWrite !== w || bus.MemSize !== exp_sz || bus.MemSE !== se ||
            bus.MemAddress !== addr || bus.MemDataIn !== wd) fields_ok = 1'b0;
      end
      if (bus.RespValid) begin
        resp_at = i; got_data = bus.RespData; got_err = bus.RespErr;
      end
    end
    exp_data = exp_q.pop_front();
    check_eq("mem_enable_width", en_cnt, mis ? 0 : WAIT + 1);
    check_eq("resp_latency", resp_at, mis ? 1 : WAIT + 2);
    check_eq("resp_data", got_data, exp_data);
    check_eq("resp_err", 32'(got_err), 32'(mis));
    if (mis) check_eq("mem_addr_kept", 32'(bus.MemAddress), 32'(prev_addr));
    else     check_eq("mem_fields", 32'(fields_ok), 32'd1);
    @(negedge Clk);
    check_eq("resp_one_cycle", {30'd0, bus.RespValid, bus.RespErr}, 32'd0);
    check_eq("resp_data_hold", bus.RespData, got_data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, r0;
    logic [8:0] ra;
    Reset_n = 1'b0;
    bus.ReqValid = 1'b0;
    drive_fields(1'b0, 2'b00, 1'b0, 9'h0, 32'h0);
    #1;
    check_eq("rst_ready", 32'(bus.ReqReady), 32'd0);
    check_eq("rst_outputs", {29'd0, bus.MemEnable, bus.RespValid, bus.RespErr}, 32'd0);
    check_eq("rst_resp_data", bus.RespData, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check_eq("ready_after_rst", 32'(bus.ReqReady), 32'd1);

    // Store word, then sub-word loads with and without sign extension.
    run_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
    run_req(1'b0, 2'b00, 1'b1, 9'h010, 32'h0);
    check_eq("load_byte_se", bus.RespData, 32'hFFFFFFDE);
    run_req(1'b1, 2'b00, 1'b0, 9'h010, 32'h000000DE);
    run_req(1'b0, 2'b00, 1'b0, 9'h010, 32'h0);
    check_eq("load_byte_ze", bus.RespData, 32'h000000DE);
    run_req(1'b0, 2'b11, 1'b0, 9'h010, 32'h0);
    // Misaligned word load: rejected only when alignment checking is built in.
    run_req(1'b0, 2'b10, 1'b0, 9'h013, 32'h0);
    run_req(1'b1, 2'b01, 1'b0, 9'h1FF, 32'h0000A55A);

    // Back-to-back: ReqValid stays high across two loads.
    @(negedge Clk);
    acc_q.delete();
    r0 = resp_cnt;
    bus.ReqValid = 1'b1;
    drive_fields(1'b0, 2'b10, 1'b0, 9'h010, 32'h11111111);
    for (int k = 0; k < 40 && acc_q.size() < 1; k++) @(negedge Clk);
    drive_fields(1'b0, 2'b00, 1'b1, 9'h011, 32'h22222222);
    for (int k = 0; k < 40 && acc_q.size() < 2; k++) @(negedge Clk);
    bus.ReqValid = 1'b0;
    check_eq("b2b_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) check_eq("b2b_spacing", acc_q[1] - acc_q[0], WAIT + 3);
    repeat (WAIT + 4) @(negedge Clk);
    check_eq("b2b_resp_count", resp_cnt - r0, 2);

    // Reset during the access window of a store.
    @(negedge Clk);
    acc_q.delete();
    r0 = resp_cnt;
    bus.ReqValid = 1'b1;
    drive_fields(1'b1, 2'b10, 1'b0, 9'h1F0, 32'hCAFEF00D);
    wait_ready();
    @(negedge Clk);
    bus.ReqValid = 1'b0;
    if (WAIT > 0) @(negedge Clk);
    check_eq("abort_pre_enable", 32'(bus.MemEnable), 32'd1);
    Reset_n = 1'b0;
    #1;
    check_eq("abort_enable_low", 32'(bus.MemEnable), 32'd0);
    check_eq("abort_ready_low", 32'(bus.ReqReady), 32'd0);
    check_eq("abort_addr_clr", 32'(bus.MemAddress), 32'd0);
    repeat (3) @(negedge Clk);
    check_eq("abort_no_resp", resp_cnt - r0, 0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check_eq("abort_ready_back", 32'(bus.ReqReady), 32'd1);
    for (int i = 0; i < 4; i++) shadow[9'h1F0 + 9'(i)] = mem[9'h1F0 + 9'(i)];

    // Randomized traffic concentrated on a small window so loads hit stored data.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) ra = 9'h1FC + 9'($urandom_range(0, 3));
      else                           ra = 9'($urandom_range(0, 63));
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ra, $urandom);
    end

    a0 = stab_err;
    check_eq("mem_stable_while_enabled", a0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the pipeline MEM stage over a valid/ready handshake.
- Drives the memory's Enable/ReadWrite/SE/Size/Address/DataIn pins and holds them stable for a programmable access window.
- Captures the memory's DataOut and returns one response per request.
- Sits between the MEM-stage pipeline register and the data memory.

Parameters:
ADDR_W, 9, byte-address width (512-byte memory)
WAIT_CYCLES, 1, extra cycles MemEnable is held before DataOut is sampled; legal range 0..15

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
ReqValid  input  1  request present
ReqReady  output  1  controller can accept a request
ReqWrite  input  1  1 = store, 0 = load
ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 word
ReqSE  input  1  sign-extend sub-word loads
ReqAddr  input  ADDR_W  byte address
ReqWData  input  32  store data, right-justified
RespValid  output  1  one-cycle response strobe
RespData  output  32  load result; 0 for stores
RespErr  output  1  request rejected (see Optional Feature)
MemEnable  output  1  memory enable
MemReadWrite  output  1  1 = write, 0 = read
MemSE  output  1  sign-extend select to memory
MemSize  output  2  access size to memory
MemAddress  output  ADDR_W  memory byte address
MemDataIn  output  32  store data to memory
MemDataOut  input  32  read data from memory

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State returns to IDLE.
  - All outputs go to 0, including ReqReady.
  - ReqReady rises on the first Clk edge after Reset_n deasserts.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - ReqReady = 1.
  - An edge with ReqValid & ReqReady accepts the request: latch Write/Size/SE/Addr/WData into the Mem* output registers, load the wait counter with WAIT_CYCLES, clear ReqReady, go to ACCESS.
- ACCESS:
  - MemEnable = 1 and all Mem* outputs are frozen.
  - The counter decrements each edge.
  - On the edge where the counter is 0:
    - load: RespData <= MemDataOut
    - store: RespData <= 0
    - then MemEnable <= 0, RespValid <= 1, go to RESP.
  - MemEnable is therefore high for exactly WAIT_CYCLES+1 cycles.
- RESP:
  - RespValid is high for exactly one cycle; there is no response backpressure.
  - Next edge: RespValid <= 0, ReqReady <= 1, go to IDLE.
- Latency: accept at edge E0 puts RespValid high in the cycle after edge E(WAIT_CYCLES+1).
- Throughput: one request per WAIT_CYCLES+3 cycles.
- Signal hold rules:
  - MemReadWrite, MemSize, MemSE, MemAddress and MemDataIn hold their last values until the next accept. They never change in a cycle in which MemEnable is 1.
  - RespData holds its value until the next capture.
- ReqSize 11 is forwarded as 10.
- Sign/zero extension is performed by the memory. The controller forwards ReqSE unchanged and does not alter MemDataOut.
- Address wrap: ReqAddr is forwarded unchanged; address+n overflow is the memory's concern.
- ReqValid while busy: ignored; the requester must hold ReqValid until ReqReady is seen.
- Reset mid-ACCESS: MemEnable drops immediately and no RespValid is issued for the aborted request. A partially written store is not rolled back.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - In IDLE, an accepted request is misaligned if it is a halfword with Addr[0]=1, or a word (size 10 or 11) with Addr[1:0]!=00.
  - A misaligned request skips ACCESS: MemEnable never asserts and the Mem* outputs keep their previous values.
  - The FSM goes directly to RESP with RespErr=1 and RespData=0, so RespValid is high in the cycle after the accept edge.
  - RespErr clears with RespValid.
- Undefined: RespErr is constant 0 and every request is forwarded to memory.

Decomposition:
- Package mem_access_pkg holds:
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - state encoding IDLE/ACCESS/RESP
  - a misalignment function (size, addr[1:0])
- No sub-module: FSM, counter and output registers live in one module.

Test Plan:
1. WAIT_CYCLES=1, store word 0xDEADBEEF at 0x010 -> MemEnable=1 for 2 cycles, MemReadWrite=1, MemSize=10, MemDataIn=0xDEADBEEF; RespValid 1 cycle later with RespData=0, RespErr=0.
2. Load byte, SE=1, at 0x010 with the memory model returning 0xFFFFFFDE -> MemSE=1, MemSize=00, MemReadWrite=0; RespData=0xFFFFFFDE on RespValid. Repeat with SE=0 and model returning 0x000000DE -> MemSE=0, RespData=0x000000DE.
3. Back-to-back: ReqValid held high with two queued loads, WAIT_CYCLES=1 -> the second accept occurs exactly 4 cycles after the first; Mem* outputs never change while MemEnable=1.
4. Reset_n pulled low in the second ACCESS cycle of a store -> MemEnable=0 immediately, no RespValid, ReqReady=0; ReqReady=1 one edge after release.
5. Macro defined, load word at 0x013 -> MemEnable stays 0, RespValid and RespErr both 1 one cycle after accept. Macro undefined, same request -> forwarded to memory with MemAddress=0x013, RespErr=0.
6. WAIT_CYCLES=0 and WAIT_CYCLES=3 builds -> MemEnable width of 1 and 4 cycles respectively; RespValid timing matches the latency rule in Behaviour.
